// File: rtl/demux_pkg.sv
// Shared constants and types for the registered 1-to-4 write-side demultiplexer.
package demux_pkg;

  localparam logic [1:0] SEL_A = 2'd0;
  localparam logic [1:0] SEL_B = 2'd1;
  localparam logic [1:0] SEL_C = 2'd2;
  localparam logic [1:0] SEL_D = 2'd3;

  localparam int unsigned DATA_W_DEFAULT = 16;
  localparam int unsigned NUM_SLOTS      = 4;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/demux_slot.sv
// One-entry holding register with valid flag; load has priority over ack.
// The saturating transfer counter exists only when DEMUX_COUNT_EN is defined.
module demux_slot
  import demux_pkg::*;
#(
  parameter int unsigned W = DATA_W_DEFAULT
`ifdef DEMUX_COUNT_EN
  ,
  parameter int unsigned CNT_W = 8
`endif
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         ack,
  input  logic [W-1:0] data_in,
  output logic [W-1:0] data,
  output logic         valid
`ifdef DEMUX_COUNT_EN
  ,
  output logic [CNT_W-1:0] cnt
`endif
);

  slot_state_e state;

  // Slot state and data; data is kept after release so consumers may re-read it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SLOT_EMPTY;
      data  <= '0;
    end else begin
      case (state)
        SLOT_EMPTY: if (load) state <= SLOT_FULL;
        SLOT_FULL:  if (ack && !load) state <= SLOT_EMPTY;
        default:    state <= SLOT_EMPTY;
      endcase
      if (load) data <= data_in;
    end
  end

  assign valid = (state == SLOT_FULL);

`ifdef DEMUX_COUNT_EN
  // Accepted-load counter, holds at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: rtl/demux_4output_reg.sv
// Registered 1-to-4 demultiplexer: select decode, in_ready mux and port packing
// around four demux_slot holding registers. Optional counters: DEMUX_COUNT_EN.
module demux_4output_reg
  import demux_pkg::*;
#(
  parameter int unsigned W     = DATA_W_DEFAULT,
  parameter int unsigned CNT_W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] in_data,
  input  logic [1:0]   in_sel,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_a,
  output logic [W-1:0] out_b,
  output logic [W-1:0] out_c,
  output logic [W-1:0] out_d,
  output logic [3:0]   out_valid,
  input  logic [3:0]   out_ack
`ifdef DEMUX_COUNT_EN
  ,
  output logic [4*CNT_W-1:0] xfer_cnt
`endif
);

  logic [3:0]   sel_hot;
  logic [3:0]   load;
  logic         accept;
  logic [W-1:0] slot_data [NUM_SLOTS];

  // One-hot destination decode.
  always_comb begin
    sel_hot = 4'b0000;
    case (in_sel)
      SEL_A:   sel_hot = 4'b0001;
      SEL_B:   sel_hot = 4'b0010;
      SEL_C:   sel_hot = 4'b0100;
      SEL_D:   sel_hot = 4'b1000;
      default: sel_hot = 4'b0000;
    endcase
  end

  // A full slot can still accept when its consumer drains it in the same cycle.
  assign in_ready = !reset && (!out_valid[in_sel] || out_ack[in_sel]);
  assign accept   = in_valid && in_ready;
  assign load     = sel_hot & {4{accept}};

  for (genvar i = 0; i < 4; i++) begin : g_slot
    demux_slot #(
      .W    (W)
`ifdef DEMUX_COUNT_EN
      ,
      .CNT_W(CNT_W)
`endif
    ) u_slot (
      .clk    (clk),
      .reset  (reset),
      .load   (load[i]),
      .ack    (out_ack[i]),
      .data_in(in_data),
      .data   (slot_data[i]),
      .valid  (out_valid[i])
`ifdef DEMUX_COUNT_EN
      ,
      .cnt    (xfer_cnt[i*CNT_W +: CNT_W])
`endif
    );
  end

  assign out_a = slot_data[SEL_A];
  assign out_b = slot_data[SEL_B];
  assign out_c = slot_data[SEL_C];
  assign out_d = slot_data[SEL_D];

`ifndef DEMUX_COUNT_EN
  if (CNT_W == 0) begin : g_bad_cnt_w
    $error("CNT_W must be nonzero");
  end
`endif

endmodule
